// File: rtl/rs_dispatch_pkg.sv
// ============================================================================
// Module      : rs_dispatch_pkg
// Description : Shared constants for the dispatch router: station ids and
//               default widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rs_dispatch_pkg;

  // Station ids of the existing execution units
  localparam int RS_ALU  = 0;
  localparam int RS_BRA  = 1;
  localparam int RS_LDST = 2;
  localparam int RS_MUL  = 3;

  // Default widths
  localparam int DEF_RS_ID_W  = 2;
  localparam int DEF_DATA_W   = 64;
  localparam int DEF_CREDIT_W = 4;

endpackage

`default_nettype wire

// File: rtl/rs_credit_ctr.sv
// ============================================================================
// Module      : rs_credit_ctr
// Description : Free-entry credit counter for one reservation station.
//               Reloads to RS_DEPTH on reset/flush, saturates at RS_DEPTH
//               and flags a return that would overflow it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_credit_ctr #(
  parameter int CREDIT_W = 4,
  parameter int RS_DEPTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                dec,
  input  logic                inc,
  output logic [CREDIT_W-1:0] count,
  output logic                overflow
);

  localparam logic [CREDIT_W-1:0] C_DEPTH = CREDIT_W'(RS_DEPTH);

  logic [CREDIT_W-1:0] r_count;

  assign count = r_count;

  // A lone return against a full station is a protocol error; flush drops it
  assign overflow = inc & ~dec & ~flush & (r_count == C_DEPTH);

  // Credit state: reload, then net change of dec/inc with saturation at depth
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_count <= C_DEPTH;
    end else if (dec && !inc) begin
      r_count <= r_count - 1'b1;
    end else if (inc && !dec && (r_count != C_DEPTH)) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rs_dispatch_router.sv
// ============================================================================
// Module      : rs_dispatch_router
// Description : Registered, credit flow-controlled, flushable dispatch from
//               decode to NUM_RS reservation stations.
//               Optional macro RS_DISPATCH_SKID_EN adds a one-entry input skid
//               so in_ready no longer depends on the target station's credit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_dispatch_router
  import rs_dispatch_pkg::*;
#(
  parameter int NUM_RS   = 4,
  parameter int RS_ID_W  = DEF_RS_ID_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int RS_DEPTH = 8,
  parameter int CREDIT_W = DEF_CREDIT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [RS_ID_W-1:0]         in_rs_id,
  input  logic [DATA_W-1:0]          in_data,
  output logic [NUM_RS-1:0]          out_valid,
  output logic [DATA_W-1:0]          out_data,
  input  logic [NUM_RS-1:0]          credit_ret,
  output logic [NUM_RS*CREDIT_W-1:0] credit,
  output logic                       err
);

  localparam int               C_ID_SPACE = 1 << RS_ID_W;
  localparam logic [RS_ID_W:0] C_NUM_RS   = (RS_ID_W+1)'(NUM_RS);

  logic [CREDIT_W-1:0]   w_count [NUM_RS];
  logic [NUM_RS-1:0]     w_overflow;
  logic [NUM_RS-1:0]     w_onehot;
  logic [C_ID_SPACE-1:0] w_nz_ext;     // credit != 0, zero-padded over the id space

  logic                  w_cand_valid; // instruction presented for dispatch this cycle
  logic [RS_ID_W-1:0]    w_cand_id;
  logic [DATA_W-1:0]     w_cand_data;
  logic                  w_cand_id_ok;
  logic                  w_dispatch;
  logic                  w_drop;

  logic [NUM_RS-1:0]     r_out_valid;
  logic [DATA_W-1:0]     r_out_data;
  logic                  r_err;

  // Per-station "has credit" view indexable by any id; unused ids read as 0
  always_comb begin
    w_nz_ext = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      w_nz_ext[i] = (w_count[i] != '0);
    end
  end

`ifdef RS_DISPATCH_SKID_EN
  logic               r_skid_valid;
  logic [RS_ID_W-1:0] r_skid_id;
  logic [DATA_W-1:0]  r_skid_data;
  logic               w_accept;
  logic               w_park;

  assign in_ready     = ~r_skid_valid & ~flush;
  assign w_accept     = in_valid & in_ready;
  // A parked instruction always goes first; the input is closed while it waits
  assign w_cand_valid = (r_skid_valid | w_accept) & ~flush;
  assign w_cand_id    = r_skid_valid ? r_skid_id   : in_rs_id;
  assign w_cand_data  = r_skid_valid ? r_skid_data : in_data;
  assign w_park       = w_cand_valid & w_cand_id_ok & ~w_nz_ext[w_cand_id];

  // Hold an instruction whose station is full until a credit returns
  always_ff @(posedge clk) begin
    if (reset) begin
      r_skid_valid <= 1'b0;
      r_skid_id    <= '0;
      r_skid_data  <= '0;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
    end else begin
      r_skid_valid <= w_park;
      if (w_park) begin
        r_skid_id   <= w_cand_id;
        r_skid_data <= w_cand_data;
      end
    end
  end
`else
  // Unknown ids are always accepted (then dropped) so decode cannot stall on them
  assign in_ready     = ~flush & (~w_cand_id_ok | w_nz_ext[in_rs_id]);
  assign w_cand_valid = in_valid & in_ready;
  assign w_cand_id    = in_rs_id;
  assign w_cand_data  = in_data;
`endif

  assign w_cand_id_ok = ({1'b0, w_cand_id} < C_NUM_RS);
  assign w_dispatch   = w_cand_valid & w_cand_id_ok & w_nz_ext[w_cand_id];
  assign w_drop       = w_cand_valid & ~w_cand_id_ok;

  // One-hot station strobe for the instruction dispatched this cycle
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      w_onehot[i] = w_dispatch & (w_cand_id == RS_ID_W'(i));
    end
  end

  for (genvar i = 0; i < NUM_RS; i++) begin : g_station
    rs_credit_ctr #(
      .CREDIT_W (CREDIT_W),
      .RS_DEPTH (RS_DEPTH)
    ) u_ctr (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .dec      (w_onehot[i]),
      .inc      (credit_ret[i]),
      .count    (w_count[i]),
      .overflow (w_overflow[i])
    );
    assign credit[i*CREDIT_W +: CREDIT_W] = w_count[i];
  end

  // Registered station write port and sticky error flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= flush ? '0 : w_onehot;
      if (w_dispatch && !flush) begin
        r_out_data <= w_cand_data;
      end
      if (w_drop || (|w_overflow)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err       = r_err;

endmodule

`default_nettype wire
